// File: rtl/lint_rr_arbiter.sv
// rtl/lint_rr_arbiter.sv - N-to-1 round-robin LINT arbiter, single transaction outstanding
module lint_rr_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BE_WIDTH    = DATA_WIDTH / 8,
    parameter int ID_WIDTH    = 10,
    parameter int AUX_WIDTH   = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_MASTERS-1:0]          m_req_i,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_add_i,
    input  logic [NUM_MASTERS-1:0]          m_wen_i,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
    input  logic [NUM_MASTERS*BE_WIDTH-1:0] m_be_i,
    input  logic [NUM_MASTERS*AUX_WIDTH-1:0] m_aux_i,
    input  logic [NUM_MASTERS*ID_WIDTH-1:0] m_ID_i,
    output logic [NUM_MASTERS-1:0]          m_gnt_o,
    output logic [NUM_MASTERS-1:0]          m_r_valid_o,
    output logic [DATA_WIDTH-1:0]           m_r_rdata_o,
    output logic                            m_r_opc_o,
    output logic [AUX_WIDTH-1:0]            m_r_aux_o,
    output logic [ID_WIDTH-1:0]             m_r_ID_o,
    output logic                            s_req_o,
    output logic [ADDR_WIDTH-1:0]           s_add_o,
    output logic                            s_wen_o,
    output logic [DATA_WIDTH-1:0]           s_wdata_o,
    output logic [BE_WIDTH-1:0]             s_be_o,
    output logic [AUX_WIDTH-1:0]            s_aux_o,
    output logic [ID_WIDTH-1:0]             s_ID_o,
    input  logic                            s_gnt_i,
    input  logic                            s_r_valid_i,
    input  logic [DATA_WIDTH-1:0]           s_r_rdata_i,
    input  logic                            s_r_opc_i,
    input  logic [AUX_WIDTH-1:0]            s_r_aux_i,
    input  logic [ID_WIDTH-1:0]             s_r_ID_i
);
    localparam int PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_MASTERS - 1);

    typedef enum logic {ARB, WAIT_RSP} state_t;

    state_t           state, state_next;
    logic [PTR_W-1:0] prio_ptr, owner, pick, winner, idx;
    logic             locked, found, s_req, handshake;

    // Rotating search starting at prio_ptr; first asserted request wins.
    always_comb begin
        pick  = prio_ptr;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx = PTR_W'((int'(prio_ptr) + i) % NUM_MASTERS);
            if (!found && m_req_i[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // A stalled request keeps its master selected until the slave grants it.
    assign winner    = locked ? owner : pick;
    assign s_req     = rst_n && (state == ARB) && (locked || (|m_req_i));
    assign handshake = s_req && s_gnt_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ARB;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ARB:      if (handshake) state_next = WAIT_RSP;
            WAIT_RSP: if (s_r_valid_i) state_next = ARB;
            default:  state_next = ARB;
        endcase
    end

    always_comb begin
        m_gnt_o     = '0;
        m_r_valid_o = '0;
        if (handshake) m_gnt_o[winner] = 1'b1;
        if (rst_n && (state == WAIT_RSP) && s_r_valid_i) m_r_valid_o[owner] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_ptr <= '0;
            owner    <= '0;
            locked   <= 1'b0;
        end else if ((state == ARB) && s_req) begin
            owner  <= winner;
            locked <= ~s_gnt_i;
            if (s_gnt_i) prio_ptr <= (winner == LAST) ? '0 : winner + 1'b1;
        end
    end

    assign s_req_o   = s_req;
    assign s_add_o   = m_add_i[winner*ADDR_WIDTH +: ADDR_WIDTH];
    assign s_wen_o   = m_wen_i[winner];
    assign s_wdata_o = m_wdata_i[winner*DATA_WIDTH +: DATA_WIDTH];
    assign s_be_o    = m_be_i[winner*BE_WIDTH +: BE_WIDTH];
    assign s_aux_o   = m_aux_i[winner*AUX_WIDTH +: AUX_WIDTH];
    assign s_ID_o    = m_ID_i[winner*ID_WIDTH +: ID_WIDTH];

    assign m_r_rdata_o = s_r_rdata_i;
    assign m_r_opc_o   = s_r_opc_i;
    assign m_r_aux_o   = s_r_aux_i;
    assign m_r_ID_o    = s_r_ID_i;
endmodule

// File: tb/tb_lint_rr_arbiter.sv
// tb/tb_lint_rr_arbiter.sv - self-checking bench for lint_rr_arbiter
module tb_lint_rr_arbiter;
    localparam int N = 4;

    logic          clk, rst_n;
    logic [N-1:0]  m_req_i, m_wen_i, m_gnt_o, m_r_valid_o;
    logic [N*32-1:0] m_add_i, m_wdata_i;
    logic [N*4-1:0]  m_be_i;
    logic [N*8-1:0]  m_aux_i;
    logic [N*10-1:0] m_ID_i;
    logic [31:0]   m_r_rdata_o, s_add_o, s_wdata_o, s_r_rdata_i;
    logic          m_r_opc_o, s_req_o, s_wen_o, s_gnt_i, s_r_valid_i, s_r_opc_i;
    logic [7:0]    m_r_aux_o, s_aux_o, s_r_aux_i;
    logic [9:0]    m_r_ID_o, s_ID_o, s_r_ID_i;
    logic [3:0]    s_be_o;

    int checks = 0;
    int failures = 0;

    lint_rr_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m_req_i(m_req_i), .m_add_i(m_add_i), .m_wen_i(m_wen_i), .m_wdata_i(m_wdata_i),
        .m_be_i(m_be_i), .m_aux_i(m_aux_i), .m_ID_i(m_ID_i),
        .m_gnt_o(m_gnt_o), .m_r_valid_o(m_r_valid_o), .m_r_rdata_o(m_r_rdata_o),
        .m_r_opc_o(m_r_opc_o), .m_r_aux_o(m_r_aux_o), .m_r_ID_o(m_r_ID_o),
        .s_req_o(s_req_o), .s_add_o(s_add_o), .s_wen_o(s_wen_o), .s_wdata_o(s_wdata_o),
        .s_be_o(s_be_o), .s_aux_o(s_aux_o), .s_ID_o(s_ID_o),
        .s_gnt_i(s_gnt_i), .s_r_valid_i(s_r_valid_i), .s_r_rdata_i(s_r_rdata_i),
        .s_r_opc_i(s_r_opc_i), .s_r_aux_i(s_r_aux_i), .s_r_ID_i(s_r_ID_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        m_req_i = '0; m_wen_i = '0; m_add_i = '0; m_wdata_i = '0;
        m_be_i = '0; m_aux_i = '0; m_ID_i = '0;
        s_gnt_i = 0; s_r_valid_i = 0; s_r_rdata_i = '0; s_r_opc_i = 0;
        s_r_aux_i = '0; s_r_ID_i = '0;
        for (int k = 0; k < N; k++) begin
            m_add_i[k*32 +: 32] = 32'h1000_0000 + 32'(k) * 32'h100;
            m_ID_i[k*10 +: 10]  = 10'(k + 1);
        end
    endtask

    task automatic do_reset;
        clear_inputs();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst_n = 0;
        m_req_i = 4'b1111; s_gnt_i = 1; s_r_valid_i = 1;
        #4;
        checks++; if (m_gnt_o !== 4'b0000) begin failures++; $display("FAIL reset_gnt: got %b expected 0000", m_gnt_o); end
        checks++; if (m_r_valid_o !== 4'b0000) begin failures++; $display("FAIL reset_rvalid: got %b expected 0000", m_r_valid_o); end
        checks++; if (s_req_o !== 1'b0) begin failures++; $display("FAIL reset_sreq: got %b expected 0", s_req_o); end
        tick();
        clear_inputs();
        tick();
        rst_n = 1;
    endtask

    task automatic test_single;
        do_reset();
        m_req_i = 4'b0100; m_add_i[2*32 +: 32] = 32'h1A10_0004; s_gnt_i = 1;
        #4;
        checks++; if (s_req_o !== 1'b1) begin failures++; $display("FAIL single_sreq: got %b expected 1", s_req_o); end
        checks++; if (s_add_o !== 32'h1A10_0004) begin failures++; $display("FAIL single_addr: got %h expected 1a100004", s_add_o); end
        checks++; if (m_gnt_o !== 4'b0100) begin failures++; $display("FAIL single_gnt: got %b expected 0100", m_gnt_o); end
        tick();
        m_req_i = '0; s_gnt_i = 0;
        for (int c = 0; c < 2; c++) begin
            #4;
            checks++; if (m_r_valid_o !== 4'b0000) begin failures++; $display("FAIL single_early_rvalid: got %b expected 0000", m_r_valid_o); end
            tick();
        end
        s_r_valid_i = 1; s_r_rdata_i = 32'hDEAD_BEEF;
        #4;
        checks++; if (m_r_valid_o !== 4'b0100) begin failures++; $display("FAIL single_rvalid: got %b expected 0100", m_r_valid_o); end
        checks++; if (m_r_rdata_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL single_rdata: got %h expected deadbeef", m_r_rdata_o); end
        tick();
        s_r_valid_i = 0;
    endtask

    task automatic test_round_robin;
        int order [5] = '{0, 1, 2, 3, 0};
        do_reset();
        m_req_i = 4'b1111; s_gnt_i = 1;
        for (int g = 0; g < 5; g++) begin
            s_r_valid_i = 0;
            #4;
            checks++; if (m_gnt_o !== 4'(1 << order[g])) begin failures++; $display("FAIL rr_gnt%0d: got %b expected %b", g, m_gnt_o, 4'(1 << order[g])); end
            tick();
            s_r_valid_i = 1;
            #4;
            checks++; if (m_r_valid_o !== 4'(1 << order[g])) begin failures++; $display("FAIL rr_rvalid%0d: got %b expected %b", g, m_r_valid_o, 4'(1 << order[g])); end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_lock;
        do_reset();
        m_req_i = 4'b0010; s_gnt_i = 0;
        for (int c = 0; c < 3; c++) begin
            #4;
            checks++; if (s_req_o !== 1'b1 || m_gnt_o !== 4'b0000) begin failures++; $display("FAIL lock_wait: sreq %b gnt %b expected 1 0000", s_req_o, m_gnt_o); end
            tick();
        end
        m_req_i = 4'b0011;
        #4;
        checks++; if (s_add_o !== 32'h1000_0100) begin failures++; $display("FAIL lock_addr: got %h expected 10000100", s_add_o); end
        tick();
        s_gnt_i = 1;
        #4;
        checks++; if (m_gnt_o !== 4'b0010) begin failures++; $display("FAIL lock_gnt: got %b expected 0010", m_gnt_o); end
        checks++; if (s_ID_o !== 10'd2) begin failures++; $display("FAIL lock_id: got %0d expected 2", s_ID_o); end
        tick();
        m_req_i = '0; s_gnt_i = 0; s_r_valid_i = 1;
        tick();
        s_r_valid_i = 0;
    endtask

    task automatic test_stall;
        do_reset();
        m_req_i = 4'b0100; s_gnt_i = 1;
        tick();
        m_req_i = 4'b1001;
        for (int c = 0; c < 2; c++) begin
            #4;
            checks++; if (m_gnt_o !== 4'b0000 || s_req_o !== 1'b0) begin failures++; $display("FAIL stall_hold: gnt %b sreq %b expected 0000 0", m_gnt_o, s_req_o); end
            tick();
        end
        s_r_valid_i = 1;
        #4;
        checks++; if (m_r_valid_o !== 4'b0100 || m_gnt_o !== 4'b0000) begin failures++; $display("FAIL stall_rsp: rvalid %b gnt %b expected 0100 0000", m_r_valid_o, m_gnt_o); end
        tick();
        s_r_valid_i = 0;
        #4;
        checks++; if (m_gnt_o !== 4'b1000) begin failures++; $display("FAIL stall_next_gnt: got %b expected 1000", m_gnt_o); end
        tick();
        m_req_i = '0; s_r_valid_i = 1;
        tick();
        s_r_valid_i = 0;
    endtask

    task automatic test_spurious;
        do_reset();
        s_r_valid_i = 1; s_gnt_i = 1;
        #4;
        checks++; if (m_r_valid_o !== 4'b0000 || s_req_o !== 1'b0) begin failures++; $display("FAIL spurious_rsp: rvalid %b sreq %b expected 0000 0", m_r_valid_o, s_req_o); end
        tick();
        s_r_valid_i = 0; m_req_i = 4'b0001;
        #4;
        checks++; if (m_gnt_o !== 4'b0001) begin failures++; $display("FAIL spurious_after_gnt: got %b expected 0001", m_gnt_o); end
        tick();
        m_req_i = '0; s_gnt_i = 0; s_r_valid_i = 1;
        tick();
        s_r_valid_i = 0;
    endtask

    task automatic test_reset_mid;
        do_reset();
        m_req_i = 4'b0010; s_gnt_i = 1;
        tick();
        m_req_i = '0;
        #2;
        rst_n = 0;
        #1;
        checks++; if (m_gnt_o !== 4'b0000 || s_req_o !== 1'b0 || m_r_valid_o !== 4'b0000) begin failures++; $display("FAIL midreset_out: gnt %b sreq %b rvalid %b expected 0", m_gnt_o, s_req_o, m_r_valid_o); end
        tick();
        rst_n = 1;
        s_r_valid_i = 1;
        #4;
        checks++; if (m_r_valid_o !== 4'b0000) begin failures++; $display("FAIL midreset_late_rsp: got %b expected 0000", m_r_valid_o); end
        tick();
        s_r_valid_i = 0; m_req_i = 4'b1010;
        #4;
        checks++; if (m_gnt_o !== 4'b0010) begin failures++; $display("FAIL midreset_ptr: got %b expected 0010", m_gnt_o); end
        tick();
        m_req_i = '0; s_r_valid_i = 1;
        tick();
        s_r_valid_i = 0; m_req_i = 4'b1000;
        #4;
        checks++; if (m_gnt_o !== 4'b1000) begin failures++; $display("FAIL midreset_m3: got %b expected 1000", m_gnt_o); end
        tick();
        m_req_i = '0; s_gnt_i = 0; s_r_valid_i = 1;
        tick();
        s_r_valid_i = 0;
    endtask

    task automatic test_random;
        int q[$];
        int ptr = 0;
        int lown = 0;
        bit lk = 0;
        int w;
        bit sreq, found;
        logic [3:0] exp_gnt, exp_rv;
        logic [63:0] r64;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            m_req_i = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            m_add_i = {$urandom, $urandom, $urandom, $urandom};
            m_wdata_i = {$urandom, $urandom, $urandom, $urandom};
            m_wen_i = 4'($urandom_range(0, 15));
            r64 = {$urandom, $urandom};
            m_ID_i = r64[39:0];
            s_gnt_i = 1'($urandom_range(0, 1));
            s_r_valid_i = ($urandom_range(0, 3) == 0);
            s_r_rdata_i = $urandom;
            #4;
            exp_gnt = '0; exp_rv = '0; w = 0; sreq = 0;
            if (q.size() == 0) begin
                if (lk) begin
                    w = lown; sreq = 1;
                end else begin
                    found = 0;
                    for (int k = 0; k < N; k++)
                        if (!found && m_req_i[(ptr + k) % N]) begin found = 1; w = (ptr + k) % N; end
                    sreq = found;
                end
                if (sreq && s_gnt_i) exp_gnt = 4'(1 << w);
            end else if (s_r_valid_i) begin
                exp_rv = 4'(1 << q[0]);
            end
            checks++; if (s_req_o !== sreq) begin failures++; $display("FAIL rnd_sreq c%0d: got %b expected %b", cyc, s_req_o, sreq); end
            checks++; if (m_gnt_o !== exp_gnt) begin failures++; $display("FAIL rnd_gnt c%0d: got %b expected %b", cyc, m_gnt_o, exp_gnt); end
            checks++; if (m_r_valid_o !== exp_rv) begin failures++; $display("FAIL rnd_rvalid c%0d: got %b expected %b", cyc, m_r_valid_o, exp_rv); end
            checks++; if (m_r_rdata_o !== s_r_rdata_i) begin failures++; $display("FAIL rnd_rdata c%0d: got %h expected %h", cyc, m_r_rdata_o, s_r_rdata_i); end
            if (sreq) begin
                checks++;
                if (s_add_o !== m_add_i[w*32 +: 32] || s_ID_o !== m_ID_i[w*10 +: 10] || s_wen_o !== m_wen_i[w]) begin
                    failures++;
                    $display("FAIL rnd_fields c%0d: addr %h id %h expected master %0d addr %h id %h", cyc, s_add_o, s_ID_o, w, m_add_i[w*32 +: 32], m_ID_i[w*10 +: 10]);
                end
            end
            if (q.size() != 0) begin
                if (s_r_valid_i) void'(q.pop_front());
            end else if (sreq) begin
                if (s_gnt_i) begin
                    q.push_back(w); ptr = (w + 1) % N; lk = 0;
                end else begin
                    lk = 1; lown = w;
                end
            end
            tick();
        end
        clear_inputs();
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        tick();
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_stall();
        test_spurious();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
